// File: rtl/mips32_mem_dump.sv
// Post-halt memory readback engine: reads a programmed window of data-memory
// words and streams (address, data) pairs over a valid/ready handshake.
module mips32_mem_dump #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              halted,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_READ, S_WAIT, S_SEND, S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic                mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [ADDR_W-1:0]   next_addr;
  assign next_addr = cur_addr_q + ADDR_W'(1);

  // Outputs are computed one state ahead so each one is a flop that lines up
  // with the state it belongs to.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_addr_d  = start_addr;
          remaining_d = word_count;
          busy_d      = 1'b1;
          if (word_count == '0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (halted) begin
          state_d     = S_READ;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = cur_addr_q;
        end
      end
      S_READ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        out_data_d  = mem_rd_data;
        out_addr_d  = cur_addr_q;
        out_valid_d = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cur_addr_d  = next_addr;
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          if (remaining_q == (ADDR_W+1)'(1)) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d     = S_READ;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = next_addr;
          end
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mips32_mem_dump.sv
// Bench for mips32_mem_dump: random memory contents and windows, checked
// against an expected (address, data) list derived from the memory image.
module tb_mips32_mem_dump;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          halted = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b1;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          mem_rd_en, out_valid, busy, done;
  logic [AW-1:0] mem_addr, out_addr;
  logic [DW-1:0] mem_rd_data, out_data;

  logic [DW-1:0] mem [1024];
  int vectors = 0;
  int miscompares = 0;

  mips32_mem_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk1(clk1), .rst_n(rst_n), .halted(halted), .start(start),
    .start_addr(start_addr), .word_count(word_count),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk1 = ~clk1;

  // Read data is only meaningful the cycle after a strobe; otherwise garbage.
  always @(posedge clk1) mem_rd_data <= mem_rd_en ? mem[mem_addr] : $urandom;

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_out_addr"}, out_addr, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // hdelay: cycle after start at which halted rises (0 = already high).
  task automatic xfer(input logic [AW-1:0] sa, input int cnt, input int hdelay,
                      input int stall_len, input bit ign_start, input bit drop_halt);
    logic [AW-1:0] exp_a[$];
    logic [DW-1:0] exp_d[$];
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    int words, rdens, stalled, next_valid, read_cyc, last_hs;
    bit fresh, finished;
    for (int i = 0; i < cnt; i++) begin
      exp_a.push_back(AW'((int'(sa) + i) % 1024));
      exp_d.push_back(mem[(int'(sa) + i) % 1024]);
    end
    halted = (hdelay == 0);
    out_ready = 1'b1;
    start = 1'b1;
    start_addr = sa;
    word_count = (AW+1)'(cnt);
    tick;
    start = 1'b0;
    start_addr = ~sa;
    word_count = (AW+1)'($urandom);
    read_cyc = ((hdelay > 1) ? hdelay : 1) + 1;
    next_valid = read_cyc + 2;
    fresh = 1'b1;
    finished = 1'b0;
    words = 0; rdens = 0; stalled = 0; last_hs = 0;
    ha = '0; hd = '0;
    for (int cyc = 1; cyc < 4000 && !finished; cyc++) begin
      start = 1'b0;
      if (hdelay > 0 && cyc == hdelay) halted = 1'b1;
      rdens += int'(mem_rd_en);
      if (cyc <= read_cyc) chk("rd_en_gate", mem_rd_en, cyc == read_cyc);
      if (done) begin
        chk("done_cycle", cyc, (cnt == 0) ? 1 : last_hs + 1);
        chk("word_total", words, cnt);
        chk("rd_pulses", rdens, cnt);
        chk("valid_at_done", out_valid, 0);
        finished = 1'b1;
      end else begin
        chk("busy", busy, 1);
        if (out_valid) begin
          if (fresh) begin
            chk("valid_cycle", cyc, next_valid);
            fresh = 1'b0;
            ha = out_addr;
            hd = out_data;
            if (ign_start && words == 0) begin
              start = 1'b1;
              start_addr = sa + AW'(5);
              word_count = 11'd7;
            end
          end else begin
            chk("hold_addr", out_addr, ha);
            chk("hold_data", out_data, hd);
          end
          if (words == 0 && stalled < stall_len) begin
            out_ready = 1'b0;
            stalled++;
          end else begin
            out_ready = 1'b1;
            if (words < cnt) begin
              chk("out_addr", out_addr, exp_a[words]);
              chk("out_data", out_data, exp_d[words]);
            end else begin
              chk("extra_word", words, cnt - 1);
            end
            words++;
            last_hs = cyc;
            next_valid = cyc + 3;
            fresh = 1'b1;
            if (drop_halt) halted = 1'b0;
          end
        end
      end
      if (!finished) tick;
    end
    chk("done_seen", finished, 1);
    start = 1'b0;
    tick;
    chk("busy_after", busy, 0);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[198] = 32'd120;
    mem[199] = 32'hDEAD;
    mem[200] = 32'd5;

    #12;
    chk_all_zero("reset");
    @(negedge clk1);
    rst_n = 1'b1;
    tick;

    xfer(10'd198, 3, 0, 0, 1'b0, 1'b0);
    xfer(AW'($urandom), 3, 20, 0, 1'b0, 1'b1);
    xfer(AW'($urandom), 3, 0, 5, 1'b0, 1'b0);
    xfer(10'd1023, 2, 0, 0, 1'b0, 1'b0);
    xfer(AW'($urandom), 0, 0, 0, 1'b0, 1'b0);
    xfer(AW'($urandom), 4, 0, 0, 1'b1, 1'b0);

    halted = 1'b1;
    start = 1'b1;
    start_addr = AW'($urandom);
    word_count = 11'd4;
    tick;
    start = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) tick;
    chk("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    tick;
    rst_n = 1'b1;
    tick;
    xfer(AW'($urandom), 5, 0, 0, 1'b0, 1'b0);

    xfer(AW'($urandom), 1024, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      xfer(AW'($urandom), $urandom_range(1, 8), $urandom_range(0, 3),
           $urandom_range(0, 3), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
